pipe_reg_de: RTL and testbench

PIPE_REG_DE -- requirements
Module: pipe_reg_de

---
 rtl/pipe_reg_de.sv | 104 ++++++++++
 tb/tb_pipe_reg_de.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_de.sv
// Decode-to-execute pipeline register with stall/flush handling and optional
// stall/flush performance counters (enabled by defining PIPE_PERF_CNT_EN).
module pipe_reg_de #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CTRL_W  = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               valid_d,
  input  logic [CTRL_W-1:0]  ctrl_d,
  input  logic [DATA_W-1:0]  rd1_d,
  input  logic [DATA_W-1:0]  rd2_d,
  input  logic [DATA_W-1:0]  pc_d,
  input  logic [DATA_W-1:0]  imm_ext_d,
  input  logic [DATA_W-1:0]  pc_plus4_d,
  input  logic [RADDR_W-1:0] rd_d,
  output logic               valid_e,
  output logic [CTRL_W-1:0]  ctrl_e,
  output logic [DATA_W-1:0]  rd1_e,
  output logic [DATA_W-1:0]  rd2_e,
  output logic [DATA_W-1:0]  pc_e,
  output logic [DATA_W-1:0]  imm_ext_e,
  output logic [DATA_W-1:0]  pc_plus4_e,
  output logic [RADDR_W-1:0] rd_e,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               valid_q;
  logic [CTRL_W-1:0]  ctrl_q;
  logic [DATA_W-1:0]  rd1_q;
  logic [DATA_W-1:0]  rd2_q;
  logic [DATA_W-1:0]  pc_q;
  logic [DATA_W-1:0]  imm_ext_q;
  logic [DATA_W-1:0]  pc_plus4_q;
  logic [RADDR_W-1:0] rd_q;

  // Priority rst > flush > stall > load; a bubble always carries zero control.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      pc_q       <= '0;
      imm_ext_q  <= '0;
      pc_plus4_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rd_q    <= '0;
    end else if (!stall) begin
      valid_q    <= valid_d;
      ctrl_q     <= valid_d ? ctrl_d : '0;
      rd_q       <= rd_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd2_d;
      pc_q       <= pc_d;
      imm_ext_q  <= imm_ext_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_e    = valid_q;
  assign ctrl_e     = ctrl_q;
  assign rd_e       = rd_q;
  assign rd1_e      = rd1_q;
  assign rd2_e      = rd2_q;
  assign pc_e       = pc_q;
  assign imm_ext_e  = imm_ext_q;
  assign pc_plus4_e = pc_plus4_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Saturating counters; a stall that coincides with a flush counts as a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_reg_de.sv
// Directed bench for pipe_reg_de; counter expectations follow PIPE_PERF_CNT_EN.
module tb_pipe_reg_de;

`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst, stall, flush, valid_d;
  logic [15:0] ctrl_d;
  logic [31:0] rd1_d, rd2_d, pc_d, imm_ext_d, pc_plus4_d;
  logic [4:0]  rd_d;
  logic        valid_e;
  logic [15:0] ctrl_e;
  logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e;
  logic [4:0]  rd_e;
  logic [31:0] stall_cnt, flush_cnt;

  logic        valid_e4;
  logic [15:0] ctrl_e4;
  logic [31:0] rd1_e4, rd2_e4, pc_e4, imm_ext_e4, pc_plus4_e4;
  logic [4:0]  rd_e4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  pipe_reg_de u_dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
    .imm_ext_d(imm_ext_d), .pc_plus4_d(pc_plus4_d), .rd_d(rd_d),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .pc_e(pc_e), .imm_ext_e(imm_ext_e), .pc_plus4_e(pc_plus4_e), .rd_e(rd_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_reg_de #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_d(valid_d),
    .ctrl_d(ctrl_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .pc_d(pc_d),
    .imm_ext_d(imm_ext_d), .pc_plus4_d(pc_plus4_d), .rd_d(rd_d),
    .valid_e(valid_e4), .ctrl_e(ctrl_e4), .rd1_e(rd1_e4), .rd2_e(rd2_e4),
    .pc_e(pc_e4), .imm_ext_e(imm_ext_e4), .pc_plus4_e(pc_plus4_e4), .rd_e(rd_e4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b1; flush = 1'b0; valid_d = 1'b1; ctrl_d = 16'h1234;
    rd1_d = 32'h1111_1111; rd2_d = 32'h2222_2222; pc_d = 32'h3333_3333;
    imm_ext_d = 32'h4444_4444; pc_plus4_d = 32'h5555_5555; rd_d = 5'd3;
    step();
    checks++;
    if ({valid_e, ctrl_e, rd_e} !== 22'd0) begin
      errors++; $display("FAIL reset_ctrl: got %0h expected 0", {valid_e, ctrl_e, rd_e});
    end
    checks++;
    if ({rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e} !== 160'd0) begin
      errors++; $display("FAIL reset_data: got %0h expected 0", {rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus4_e});
    end
    checks++;
    if ({stall_cnt, flush_cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_cnt: got %0h expected 0", {stall_cnt, flush_cnt});
    end
  endtask

  task automatic test_load();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid_d = 1'b1; ctrl_d = 16'h00A5;
    rd1_d = 32'h1234_5678; rd2_d = 32'h8765_4321; pc_d = 32'h0000_0010;
    imm_ext_d = 32'hFFFF_FFF0; pc_plus4_d = 32'h0000_0014; rd_d = 5'd7;
    step();
    checks++;
    if ({valid_e, ctrl_e, rd1_e, rd_e} !== {1'b1, 16'h00A5, 32'h1234_5678, 5'd7}) begin
      errors++; $display("FAIL load_main: got %0h expected %0h",
        {valid_e, ctrl_e, rd1_e, rd_e}, {1'b1, 16'h00A5, 32'h1234_5678, 5'd7});
    end
    checks++;
    if ({rd2_e, pc_e, imm_ext_e, pc_plus4_e} !==
        {32'h8765_4321, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0014}) begin
      errors++; $display("FAIL load_data: got %0h", {rd2_e, pc_e, imm_ext_e, pc_plus4_e});
    end
  endtask

  task automatic test_stall();
    pc_d = 32'h0000_0040; ctrl_d = 16'h0011; rd_d = 5'd4;
    step();
    pc_d = 32'h0000_0044; ctrl_d = 16'h0022; rd_d = 5'd5; stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++;
      if ({pc_e, ctrl_e, rd_e, valid_e} !== {32'h0000_0040, 16'h0011, 5'd4, 1'b1}) begin
        errors++; $display("FAIL stall_hold[%0d]: pc_e=%0h ctrl_e=%0h rd_e=%0d expected pc_e=40 ctrl_e=11 rd_e=4",
          i, pc_e, ctrl_e, rd_e);
      end
    end
    checks++;
    if (stall_cnt !== (PERF ? 32'd3 : 32'd0)) begin
      errors++; $display("FAIL stall_cnt3: got %0d expected %0d", stall_cnt, PERF ? 3 : 0);
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc_e !== 32'h0000_0044) begin
      errors++; $display("FAIL stall_release: pc_e=%0h expected 44", pc_e);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] sc;
    valid_d = 1'b1; ctrl_d = 16'hFFFF; rd1_d = 32'hAAAA_5555; rd_d = 5'd9;
    step();
    sc = stall_cnt;
    checks++;
    if (ctrl_e !== 16'hFFFF) begin
      errors++; $display("FAIL sf_setup: ctrl_e=%0h expected ffff", ctrl_e);
    end
    stall = 1'b1; flush = 1'b1; rd1_d = 32'h0BAD_0BAD;
    step();
    checks++;
    if ({valid_e, ctrl_e, rd_e, rd1_e} !== {1'b0, 16'h0, 5'd0, 32'hAAAA_5555}) begin
      errors++; $display("FAIL sf_bubble: valid=%0b ctrl=%0h rd=%0d rd1=%0h expected 0 0 0 aaaa5555",
        valid_e, ctrl_e, rd_e, rd1_e);
    end
    checks++;
    if ({flush_cnt, stall_cnt} !== {(PERF ? 32'd1 : 32'd0), sc}) begin
      errors++; $display("FAIL sf_cnt: flush=%0d stall=%0d expected %0d %0d",
        flush_cnt, stall_cnt, PERF ? 1 : 0, sc);
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bubble();
    valid_d = 1'b0; ctrl_d = 16'hFFFF; imm_ext_d = 32'hDEAD_BEEF; rd_d = 5'd12;
    step();
    checks++;
    if ({valid_e, ctrl_e, imm_ext_e} !== {1'b0, 16'h0, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL bubble_load: valid=%0b ctrl=%0h imm=%0h expected 0 0 deadbeef",
        valid_e, ctrl_e, imm_ext_e);
    end
  endtask

  task automatic test_saturation();
    rst = 1'b1; step(); rst = 1'b0;
    stall = 1'b1;
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (stall_cnt4 !== (PERF ? 4'hF : 4'h0)) begin
      errors++; $display("FAIL sat_cnt4: got %0h expected %0h", stall_cnt4, PERF ? 4'hF : 4'h0);
    end
    checks++;
    if (stall_cnt !== (PERF ? 32'd20 : 32'd0)) begin
      errors++; $display("FAIL sat_cnt32: got %0d expected %0d", stall_cnt, PERF ? 20 : 0);
    end
    rst = 1'b1; step();
    checks++;
    if ({stall_cnt4, stall_cnt} !== 36'd0) begin
      errors++; $display("FAIL sat_reset: got %0h expected 0", {stall_cnt4, stall_cnt});
    end
  endtask

  task automatic test_rst_mid_stall();
    rst = 1'b1; stall = 1'b1; flush = 1'b1; valid_d = 1'b1; ctrl_d = 16'h0F0F;
    rd1_d = 32'hCAFE_F00D; rd_d = 5'd21;
    step();
    checks++;
    if ({valid_e, ctrl_e, rd1_e, flush_cnt} !== 81'd0) begin
      errors++; $display("FAIL rst_mid: valid=%0b ctrl=%0h rd1=%0h fcnt=%0d expected 0",
        valid_e, ctrl_e, rd1_e, flush_cnt);
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    step();
    checks++;
    if ({valid_e, ctrl_e, rd1_e, rd_e} !== {1'b1, 16'h0F0F, 32'hCAFE_F00D, 5'd21}) begin
      errors++; $display("FAIL rst_release: valid=%0b ctrl=%0h rd1=%0h rd=%0d", valid_e, ctrl_e, rd1_e, rd_e);
    end
  endtask

  task automatic test_random();
    logic        m_valid;
    logic [15:0] m_ctrl;
    logic [31:0] m_rd1;
    logic [4:0]  m_rd;
    int          m_sc, m_fc;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; step(); rst = 1'b0;
    m_valid = 1'b0; m_ctrl = '0; m_rd1 = '0; m_rd = '0; m_sc = 0; m_fc = 0;
    for (int i = 0; i < 100; i++) begin
      stall = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 3) == 0);
      valid_d = 1'($urandom_range(0, 1)); ctrl_d = 16'($urandom);
      rd1_d = $urandom; rd_d = 5'($urandom);
      if (flush) begin
        m_valid = 1'b0; m_ctrl = '0; m_rd = '0; m_fc++;
      end else if (stall) begin
        m_sc++;
      end else begin
        m_valid = valid_d; m_ctrl = valid_d ? ctrl_d : 16'h0; m_rd1 = rd1_d; m_rd = rd_d;
      end
      step();
      checks++;
      if ({valid_e, ctrl_e, rd1_e, rd_e} !== {m_valid, m_ctrl, m_rd1, m_rd}) begin
        errors++; $display("FAIL rand_e[%0d]: got %0h expected %0h", i,
          {valid_e, ctrl_e, rd1_e, rd_e}, {m_valid, m_ctrl, m_rd1, m_rd});
      end
      checks++;
      if ({stall_cnt, flush_cnt} !== {(PERF ? 32'(m_sc) : 32'd0), (PERF ? 32'(m_fc) : 32'd0)}) begin
        errors++; $display("FAIL rand_cnt[%0d]: stall=%0d flush=%0d expected %0d %0d", i,
          stall_cnt, flush_cnt, PERF ? m_sc : 0, PERF ? m_fc : 0);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_stall_flush();
    test_bubble();
    test_saturation();
    test_rst_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
